// File: rtl/pe_mem_pkg.sv
// pe_mem_pkg: shared FSM states, widths and address translation for the PE memory responder
package pe_mem_pkg;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_BEAT, RD_END, WR_BEAT, WR_END} memState_t;
  localparam int BEAT_W = 8;
  localparam int ADDR_W = 33;
  // Byte address to beat index relative to the RAM base; low sub-beat bits fall away in the shift
  function automatic logic [ADDR_W-1:0] wordIndex(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] base, input int shift);
    return (addr - base) >> shift;
  endfunction
endpackage

// File: rtl/pe_mem_bram.sv
// pe_mem_bram: single-port RAM with byte write enables and a registered read port
module pe_mem_bram #(
  parameter int DW = 256,
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            en,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [DEPTH];
  // Byte-masked write and 1-cycle read; rdata holds while en is low
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < DW/8; b++)
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/pe_mem_responder.sv
// pe_mem_responder: memory-side responder for PE start/end read and write bursts backed by on-chip RAM
module pe_mem_responder
  import pe_mem_pkg::*;
#(
  parameter int DATAWIDTH = 256,
  parameter int DEPTH = 4096,
  parameter logic [32:0] BASE_ADDR = 33'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   StartRead,
  input  logic [32:0]            ReadAddress,
  input  logic [7:0]             ReadBurst,
  output logic [DATAWIDTH-1:0]   ReadData,
  output logic                   ReadValid,
  output logic                   EndRead,
  input  logic                   StartWrite,
  input  logic [32:0]            WriteAddress,
  input  logic [7:0]             WriteBurst,
  input  logic [DATAWIDTH-1:0]   WriteData,
  input  logic [DATAWIDTH/8-1:0] WriteStrobe,
  input  logic                   WriteReady,
  output logic                   WriteResp,
  output logic                   WriteLast,
  output logic                   EndWrite,
  output logic                   Busy,
  output logic                   Error
);
  localparam int SHIFT = $clog2(DATAWIDTH/8);
  localparam int AW = $clog2(DEPTH);
  memState_t state, nextState;
  logic [ADDR_W-1:0] idx, rdPendA, wrPendA, ldA;
  logic [BEAT_W-1:0] len, cnt, rdPendL, wrPendL, ldL;
  logic under, oor, oorQ, rdPendV, wrPendV, rdGo, wrGo, ld, popRd, popWr, pushRd, pushWr, ramEn;
  logic [DATAWIDTH/8-1:0] ramWe;
  logic [DATAWIDTH-1:0] ramQ;

  // Arbitration: pending read, new read, pending write, new write; a pend is popped only from IDLE
  assign rdGo = rdPendV || StartRead;
  assign wrGo = !rdGo && (wrPendV || StartWrite);
  assign ld = state == IDLE && (rdGo || wrGo);
  assign popRd = state == IDLE && rdPendV;
  assign popWr = state == IDLE && !rdGo && wrPendV;
  assign pushRd = StartRead && !(state == IDLE && !rdPendV);
  assign pushWr = StartWrite && !(state == IDLE && !rdGo && !wrPendV);
  assign ldA = rdGo ? (rdPendV ? rdPendA : ReadAddress) : (wrPendV ? wrPendA : WriteAddress);
  assign ldL = rdGo ? (rdPendV ? rdPendL : ReadBurst) : (wrPendV ? wrPendL : WriteBurst);
  assign oor = under || idx >= ADDR_W'(DEPTH);
  assign ReadData = ((state == RD_BEAT || state == RD_END) && !oorQ) ? ramQ : '0;
  assign Busy = state != IDLE || rdPendV || wrPendV;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end

  // Next state, handshake outputs and RAM control
  always_comb begin
    nextState = state;
    ReadValid = 1'b0;
    EndRead = 1'b0;
    WriteResp = 1'b0;
    WriteLast = 1'b0;
    EndWrite = 1'b0;
    ramEn = 1'b0;
    ramWe = '0;
    case (state)
      IDLE: nextState = rdGo ? RD_ISSUE : wrGo ? WR_BEAT : IDLE;
      RD_ISSUE: begin
        ramEn = 1'b1;
        nextState = RD_BEAT;
      end
      RD_BEAT: begin
        ReadValid = 1'b1;
        ramEn = cnt != len;
        nextState = cnt == len ? RD_END : RD_BEAT;
      end
      RD_END: begin
        EndRead = 1'b1;
        nextState = IDLE;
      end
      WR_BEAT: begin
        WriteResp = WriteReady;
        WriteLast = WriteReady && cnt == len;
        ramEn = WriteReady;
        ramWe = (WriteReady && !oor) ? WriteStrobe : '0;
        nextState = (WriteReady && cnt == len) ? WR_END : WR_BEAT;
      end
      WR_END: begin
        EndWrite = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Burst address/count tracking, pending slots and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      under <= 1'b0;
      len <= '0;
      cnt <= '0;
      oorQ <= 1'b0;
      rdPendV <= 1'b0;
      wrPendV <= 1'b0;
      rdPendA <= '0;
      wrPendA <= '0;
      rdPendL <= '0;
      wrPendL <= '0;
      Error <= 1'b0;
    end else begin
      if (ld) begin
        idx <= wordIndex(ldA, BASE_ADDR, SHIFT);
        under <= ldA < BASE_ADDR;
        len <= ldL;
        cnt <= '0;
      end else begin
        if (ramEn) idx <= idx + 1'b1;
        if (ReadValid || WriteResp) cnt <= cnt + 1'b1;
      end
      if (ramEn) oorQ <= oor;
      if (ramEn && oor) Error <= 1'b1;
      if (pushRd && rdPendV && !popRd) Error <= 1'b1;
      else if (pushRd) begin
        rdPendV <= 1'b1;
        rdPendA <= ReadAddress;
        rdPendL <= ReadBurst;
      end else if (popRd) rdPendV <= 1'b0;
      if (pushWr && wrPendV && !popWr) Error <= 1'b1;
      else if (pushWr) begin
        wrPendV <= 1'b1;
        wrPendA <= WriteAddress;
        wrPendL <= WriteBurst;
      end else if (popWr) wrPendV <= 1'b0;
    end
  end

  pe_mem_bram #(.DW(DATAWIDTH), .DEPTH(DEPTH), .AW(AW)) bram (
    .clk(clk),
    .en(ramEn),
    .we(ramWe),
    .addr(idx[AW-1:0]),
    .wdata(WriteData),
    .rdata(ramQ)
  );
endmodule

// File: tb/tb_pe_mem_responder.sv
// tb_pe_mem_responder: scoreboard bench for the PE memory responder
module tb_pe_mem_responder;
  localparam int DW = 256;
  localparam int DEPTH = 4096;
  typedef struct {
    logic [DW-1:0] d;
    int cyc;
  } rdExp_t;

  logic clk = 0, reset = 1;
  logic StartRead = 0, StartWrite = 0, WriteReady = 0;
  logic [32:0] ReadAddress = '0, WriteAddress = '0;
  logic [7:0] ReadBurst = '0, WriteBurst = '0;
  logic [DW-1:0] WriteData = '0, ReadData;
  logic [DW/8-1:0] WriteStrobe = '0;
  logic ReadValid, EndRead, WriteResp, WriteLast, EndWrite, Busy, Error;

  rdExp_t sbQ[$];
  rdExp_t e;
  logic [DW-1:0] model [int];
  logic [DW-1:0] lastD = '0, lastRd = '0;
  int nCmp = 0, nErr = 0, cyc = 0;
  int erCnt = 0, erCyc = -1, expErCyc = -1, rvCnt = 0;
  int wrRespCnt = 0, wlCyc = -1, ewCyc = -1, ewCnt = 0, firstResp = -1, tWr = 0;

  pe_mem_responder #(.DATAWIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(33'h0)) dut (
    .clk(clk), .reset(reset),
    .StartRead(StartRead), .ReadAddress(ReadAddress), .ReadBurst(ReadBurst),
    .ReadData(ReadData), .ReadValid(ReadValid), .EndRead(EndRead),
    .StartWrite(StartWrite), .WriteAddress(WriteAddress), .WriteBurst(WriteBurst),
    .WriteData(WriteData), .WriteStrobe(WriteStrobe), .WriteReady(WriteReady),
    .WriteResp(WriteResp), .WriteLast(WriteLast), .EndWrite(EndWrite),
    .Busy(Busy), .Error(Error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] expWord(input int w);
    if (w >= DEPTH || !model.exists(w)) return '0;
    return model[w];
  endfunction

  // Output monitor: pops the read scoreboard and records handshake cycles
  always @(negedge clk) begin
    if (ReadValid) begin
      rvCnt++;
      lastRd = ReadData;
      if (sbQ.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        e = sbQ.pop_front();
        chk("rd_data", ReadData, e.d);
        if (e.cyc >= 0) chk("rd_cycle", cyc, e.cyc);
        lastD = e.d;
      end
    end
    if (EndRead) begin
      erCnt++;
      erCyc = cyc;
      chk("endrd_data", ReadData, lastD);
      if (expErCyc >= 0) chk("endrd_cycle", cyc, expErCyc);
    end
    if (WriteResp) wrRespCnt++;
    if (WriteLast) wlCyc = cyc;
    if (EndWrite) begin
      ewCnt++;
      ewCyc = cyc;
    end
  end

  task automatic startRd(input int addr, input int len, input bit timed);
    int t;
    rdExp_t x;
    @(posedge clk); #1;
    StartRead = 1;
    ReadAddress = 33'(addr);
    ReadBurst = 8'(len);
    t = cyc;
    for (int i = 0; i <= len; i++) begin
      x.d = expWord(addr / 32 + i);
      x.cyc = timed ? t + 2 + i : -1;
      sbQ.push_back(x);
    end
    expErCyc = timed ? t + 3 + len : -1;
    @(posedge clk); #1;
    StartRead = 0;
  endtask

  task automatic pulseWr(input int addr, input int len);
    @(posedge clk); #1;
    StartWrite = 1;
    WriteAddress = 33'(addr);
    WriteBurst = 8'(len);
    tWr = cyc;
    @(posedge clk); #1;
    StartWrite = 0;
  endtask

  task automatic wrBeats(input int addr, input int len, input logic [DW-1:0] d0, input logic [DW/8-1:0] strb);
    int i = 0;
    logic [DW-1:0] w;
    WriteStrobe = strb;
    WriteReady = 1;
    for (int k = 0; k < 200 && i <= len; k++) begin
      WriteData = d0 + DW'(i);
      @(negedge clk);
      if (WriteResp) begin
        if (i == 0) firstResp = cyc;
        w = model.exists(addr / 32 + i) ? model[addr / 32 + i] : '0;
        for (int b = 0; b < DW/8; b++)
          if (strb[b]) w[8*b +: 8] = WriteData[8*b +: 8];
        model[addr / 32 + i] = w;
        i++;
      end
      @(posedge clk); #1;
    end
    WriteReady = 0;
    if (i <= len) chk("wr_timeout", 0, 1);
  endtask

  task automatic doWrite(input int addr, input int len, input logic [DW-1:0] d0, input logic [DW/8-1:0] strb);
    pulseWr(addr, len);
    wrBeats(addr, len, d0, strb);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitEr(input int target);
    for (int k = 0; k < 1000 && erCnt < target; k++) @(posedge clk);
    #1;
    if (erCnt < target) chk("endrd_timeout", 0, 1);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    sbQ.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, r0, ew0, rv0, er0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ReadValid", ReadValid, 0);
    chk("rst_flags", {EndRead, WriteResp, WriteLast, EndWrite, Busy, Error}, 0);
    chk("rst_ReadData", ReadData, 0);
    @(posedge clk); #1;
    reset = 0;

    r0 = wrRespCnt;
    doWrite(0, 3, 256'd1, '1);
    chk("wr_resp_cnt", wrRespCnt - r0, 4);
    chk("wr_first_cycle", firstResp, tWr + 1);
    chk("wr_last_cycle", wlCyc, tWr + 4);
    chk("endwr_cycle", ewCyc, tWr + 5);

    n = erCnt;
    startRd(0, 3, 1);
    waitEr(n + 1);
    @(negedge clk);
    chk("rd_idle_busy", Busy, 0);

    doWrite(32, 0, '0, '1);
    doWrite(32, 0, {DW{1'b1}}, 32'h0000_00FF);
    n = erCnt;
    startRd(32, 0, 0);
    waitEr(n + 1);
    chk("strobe_readback", lastRd, 256'hFFFF_FFFF_FFFF_FFFF);

    doWrite(96, 0, 256'h77, '1);
    chk("no_error_yet", Error, 0);

    n = erCnt;
    ew0 = ewCnt;
    @(posedge clk); #1;
    StartRead = 1; ReadAddress = 33'd0; ReadBurst = 8'd3;
    StartWrite = 1; WriteAddress = 33'd64; WriteBurst = 8'd1;
    for (int i = 0; i < 4; i++) sbQ.push_back('{expWord(i), cyc + 2 + i});
    expErCyc = cyc + 6;
    @(posedge clk); #1;
    StartRead = 0; WriteAddress = 33'd96; WriteBurst = 8'd0;
    @(posedge clk); #1;
    StartWrite = 0;
    @(negedge clk);
    chk("drop_error", Error, 1);
    wrBeats(64, 1, 256'h100, '1);
    waitEr(n + 1);
    chk("rd_before_wr", erCyc < firstResp, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drop_idle_busy", Busy, 0);
    chk("endwr_once", ewCnt - ew0, 1);
    n = erCnt;
    startRd(64, 1, 0);
    startRd(96, 0, 0);
    waitEr(n + 2);

    doReset();
    @(negedge clk);
    chk("reset_clears_error", Error, 0);
    doWrite(4095 * 32, 0, {8{32'h5A5A_1234}}, '1);
    n = erCnt;
    startRd(4095 * 32, 1, 1);
    waitEr(n + 1);
    chk("oor_error", Error, 1);
    chk("oor_last_zero", lastRd, 0);

    doReset();
    startRd(0, 3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sbQ.delete();
    rv0 = rvCnt;
    er0 = erCnt;
    @(negedge clk);
    chk("midrst_busy", Busy, 0);
    chk("midrst_rv", ReadValid, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_beats", rvCnt, rv0);
    chk("midrst_no_endrd", erCnt, er0);
    n = erCnt;
    startRd(0, 3, 0);
    waitEr(n + 1);
    repeat (2) @(posedge clk);
    chk("sb_empty", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
